// File: rtl/compare_block.sv
// compare_block: checks AMM read-back beats against the regenerated write pattern per descriptor.
// Optional saturating failing-descriptor counter on err_cnt_o when CMP_ERR_CNT_EN is defined.
module compare_block #(
  parameter int AMM_DATA_W = 128,
  parameter int AMM_BURST_W = 11,
  parameter int ADDR_W = 32,
  localparam int DATA_B_W = AMM_DATA_W / 8,
  localparam int ADDR_B_W = $clog2(DATA_B_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmp_en_i,
  input  logic [ADDR_W-1:0]      cmp_start_addr_i,
  input  logic [ADDR_B_W-1:0]    cmp_start_off_i,
  input  logic [ADDR_B_W-1:0]    cmp_end_off_i,
  input  logic [AMM_BURST_W-2:0] cmp_words_count_i,
  input  logic                   cmp_data_mode_i,
  input  logic [7:0]             cmp_data_ptrn_i,
  input  logic                   readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]  readdata_i,
  input  logic                   err_clr_i,
  output logic                   cmp_busy_o,
  output logic                   cmp_done_o,
  output logic                   cmp_error_o,
  output logic                   err_flag_o,
  output logic                   ovr_flag_o,
  output logic [ADDR_W-1:0]      err_addr_o,
  output logic [AMM_DATA_W-1:0]  err_data_o,
  output logic [AMM_DATA_W-1:0]  err_exp_o,
  output logic [31:0]            pass_cnt_o,
  output logic [15:0]            err_cnt_o
);
  typedef enum logic [1:0] {IDLE, ARMED, CHECK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_B_W-1:0] soff_q, eoff_q;
  logic [AMM_BURST_W-2:0] cnt_q, idx_q;
  logic mode_q;
  logic [7:0] ptrn_q, lfsr_q, exp_byte;
  logic [AMM_DATA_W-1:0] exp_word;
  logic first, last, miss, chk, drn, busy;
  logic done_q, error_q, err_flag_q, ovr_flag_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [AMM_DATA_W-1:0] err_data_q, err_exp_q;
  logic [31:0] pass_q;
  always_comb begin
    busy = state_q != IDLE;
    exp_byte = mode_q ? lfsr_q : ptrn_q;
    exp_word = {DATA_B_W{exp_byte}};
    first = idx_q == '0;
    last = idx_q == cnt_q;
    chk = readdatavalid_i && (state_q == ARMED || state_q == CHECK);
    drn = readdatavalid_i && state_q == DRAIN;
    miss = 1'b0;
    // Edge lanes outside the first/last word byte window are don't-care.
    for (int i = 0; i < DATA_B_W; i++)
      if ((!first || i >= int'(soff_q)) && (!last || i <= int'(eoff_q)) &&
          readdata_i[8*i +: 8] != exp_byte)
        miss = 1'b1;
    state_d = state_q;
    if (state_q == IDLE && cmp_en_i)
      state_d = ARMED;
    else if (chk)
      state_d = last ? IDLE : miss ? DRAIN : CHECK;
    else if (drn && last)
      state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      soff_q <= '0;
      eoff_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      mode_q <= 1'b0;
      ptrn_q <= '0;
      lfsr_q <= 8'hFF;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      err_exp_q <= '0;
      pass_q <= '0;
    end else begin
      done_q <= chk && last && !miss;
      error_q <= chk && miss;
      err_flag_q <= (chk && miss) || (err_flag_q && !err_clr_i);
      ovr_flag_q <= (busy && cmp_en_i) || (ovr_flag_q && !err_clr_i);
      if (state_q == IDLE && cmp_en_i) begin
        addr_q <= cmp_start_addr_i;
        soff_q <= cmp_start_off_i;
        eoff_q <= cmp_end_off_i;
        cnt_q <= cmp_words_count_i;
        mode_q <= cmp_data_mode_i;
        ptrn_q <= cmp_data_ptrn_i;
        lfsr_q <= cmp_data_ptrn_i;
        idx_q <= '0;
      end
      if (chk || drn) idx_q <= idx_q + 1'b1;
      if (chk) lfsr_q <= {lfsr_q[6:0], lfsr_q[6] ^ lfsr_q[1] ^ lfsr_q[0]};
      if (chk && miss) begin
        err_addr_q <= addr_q + ADDR_W'(idx_q);
        err_data_q <= readdata_i;
        err_exp_q <= exp_word;
      end
      if (chk && last && !miss && pass_q != '1) pass_q <= pass_q + 1'b1;
    end
  end
`ifdef CMP_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_cnt_q <= '0;
    else if (error_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif
  assign cmp_busy_o = busy;
  assign cmp_done_o = done_q;
  assign cmp_error_o = error_q;
  assign err_flag_o = err_flag_q;
  assign ovr_flag_o = ovr_flag_q;
  assign err_addr_o = err_addr_q;
  assign err_data_o = err_data_q;
  assign err_exp_o = err_exp_q;
  assign pass_cnt_o = pass_q;
endmodule

// File: tb/tb_compare_block.sv
// tb_compare_block: directed vectors for compare_block with hand-computed expectations.
`timescale 1ns/1ps
module tb_compare_block;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic cmp_en_i = 1'b0, cmp_data_mode_i = 1'b0, readdatavalid_i = 1'b0, err_clr_i = 1'b0;
  logic [31:0] cmp_start_addr_i = '0;
  logic [3:0] cmp_start_off_i = '0, cmp_end_off_i = '0;
  logic [9:0] cmp_words_count_i = '0;
  logic [7:0] cmp_data_ptrn_i = '0;
  logic [127:0] readdata_i = '0;
  logic cmp_busy_o, cmp_done_o, cmp_error_o, err_flag_o, ovr_flag_o;
  logic [31:0] err_addr_o, pass_cnt_o;
  logic [127:0] err_data_o, err_exp_o;
  logic [15:0] err_cnt_o;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] d;
  compare_block dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmp_en_i(cmp_en_i),
    .cmp_start_addr_i(cmp_start_addr_i), .cmp_start_off_i(cmp_start_off_i),
    .cmp_end_off_i(cmp_end_off_i), .cmp_words_count_i(cmp_words_count_i),
    .cmp_data_mode_i(cmp_data_mode_i), .cmp_data_ptrn_i(cmp_data_ptrn_i),
    .readdatavalid_i(readdatavalid_i), .readdata_i(readdata_i), .err_clr_i(err_clr_i),
    .cmp_busy_o(cmp_busy_o), .cmp_done_o(cmp_done_o), .cmp_error_o(cmp_error_o),
    .err_flag_o(err_flag_o), .ovr_flag_o(ovr_flag_o), .err_addr_o(err_addr_o),
    .err_data_o(err_data_o), .err_exp_o(err_exp_o), .pass_cnt_o(pass_cnt_o),
    .err_cnt_o(err_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction
  function automatic logic [127:0] lanes(input int so, input int eo, input logic [7:0] b);
    logic [127:0] w = '0;
    for (int i = so; i <= eo; i++) w[8*i +: 8] = b;
    return w;
  endfunction
  task automatic desc(input logic [31:0] a, input logic [3:0] so, input logic [3:0] eo,
                      input logic [9:0] wc, input logic m, input logic [7:0] p);
    cmp_en_i = 1'b1;
    cmp_start_addr_i = a;
    cmp_start_off_i = so;
    cmp_end_off_i = eo;
    cmp_words_count_i = wc;
    cmp_data_mode_i = m;
    cmp_data_ptrn_i = p;
    tick();
    cmp_en_i = 1'b0;
  endtask
  task automatic beat(input logic [127:0] w);
    readdatavalid_i = 1'b1;
    readdata_i = w;
    tick();
    readdatavalid_i = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_busy", cmp_busy_o, 0);
    check("rst_done", cmp_done_o, 0);
    check("rst_error", cmp_error_o, 0);
    check("rst_flags", {err_flag_o, ovr_flag_o}, 0);
    check("rst_addr", err_addr_o, 0);
    check("rst_data", err_data_o, 0);
    check("rst_exp", err_exp_o, 0);
    check("rst_pass", pass_cnt_o, 0);
    check("rst_errcnt", err_cnt_o, 0);
    rst_i = 1'b0;
    tick();
    // Fixed pattern, four full words.
    desc(32'd100, 4'd0, 4'd15, 10'd3, 1'b0, 8'hA5);
    check("t1_busy", cmp_busy_o, 1);
    for (int k = 0; k < 3; k++) begin
      beat(rep(8'hA5));
      check("t1_mid_pulses", {cmp_done_o, cmp_error_o}, 0);
    end
    beat(rep(8'hA5));
    check("t1_done", cmp_done_o, 1);
    check("t1_error", cmp_error_o, 0);
    check("t1_pass", pass_cnt_o, 1);
    check("t1_busy_end", cmp_busy_o, 0);
    tick();
    check("t1_done_once", cmp_done_o, 0);
    // LFSR from FF: next = {7F, 1^1^1} = FF.
    desc(32'd150, 4'd0, 4'd15, 10'd1, 1'b1, 8'hFF);
    beat(rep(8'hFF));
    beat(rep(8'hFF));
    check("t2a_done", cmp_done_o, 1);
    check("t2a_pass", pass_cnt_o, 2);
    // LFSR from 01: 01 -> 03 -> 06.
    desc(32'd160, 4'd0, 4'd15, 10'd2, 1'b1, 8'h01);
    beat(rep(8'h01));
    beat(rep(8'h03));
    beat(rep(8'h06));
    check("t2b_done", cmp_done_o, 1);
    check("t2b_pass", pass_cnt_o, 3);
    desc(32'd200, 4'd0, 4'd15, 10'd1, 1'b1, 8'h01);
    beat(rep(8'h01));
    d = rep(8'h03);
    d[7:0] = 8'h00;
    beat(d);
    check("t2c_error", cmp_error_o, 1);
    check("t2c_done", cmp_done_o, 0);
    check("t2c_addr", err_addr_o, 201);
    check("t2c_exp", err_exp_o, rep(8'h03));
    check("t2c_data", err_data_o, d);
    check("t2c_flag", err_flag_o, 1);
    check("t2c_busy", cmp_busy_o, 0);
    tick();
    check("t2c_error_once", cmp_error_o, 0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t2c_clr", err_flag_o, 0);
    // Single word, lanes 4..9 only.
    desc(32'd250, 4'd4, 4'd9, 10'd0, 1'b0, 8'h3C);
    beat(lanes(4, 9, 8'h3C));
    check("t3_done", cmp_done_o, 1);
    check("t3_pass", pass_cnt_o, 4);
    desc(32'd260, 4'd4, 4'd9, 10'd0, 1'b0, 8'h3C);
    d = lanes(4, 9, 8'h3C);
    d[79:72] = 8'h55;
    beat(d);
    check("t3_lane9_error", cmp_error_o, 1);
    check("t3_lane9_addr", err_addr_o, 260);
    check("t3_pass_hold", pass_cnt_o, 4);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    desc(32'd270, 4'd4, 4'd9, 10'd0, 1'b0, 8'h3C);
    d = lanes(4, 9, 8'h3C);
    d[87:80] = 8'h55;
    d[31:24] = 8'h55;
    beat(d);
    check("t3_lane10_done", {cmp_done_o, cmp_error_o}, 2'b10);
    check("t3_lane10_pass", pass_cnt_o, 5);
    // Mismatch on beat 0 drains the rest.
    desc(32'd300, 4'd0, 4'd15, 10'd3, 1'b0, 8'h5A);
    beat(rep(8'h00));
    check("t4_error", cmp_error_o, 1);
    check("t4_addr", err_addr_o, 300);
    check("t4_busy0", cmp_busy_o, 1);
    for (int k = 1; k < 3; k++) begin
      beat(rep(8'h00));
      check("t4_drain_busy", cmp_busy_o, 1);
      check("t4_drain_error", cmp_error_o, 0);
    end
    beat(rep(8'h00));
    check("t4_end_busy", cmp_busy_o, 0);
    check("t4_end_pulses", {cmp_done_o, cmp_error_o}, 0);
    check("t4_addr_hold", err_addr_o, 300);
    tick();
    check("t4_sticky", err_flag_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t4_clr", err_flag_o, 0);
    // Address wrap, with clear and set in the same cycle.
    desc(32'hFFFF_FFFF, 4'd0, 4'd15, 10'd1, 1'b0, 8'h11);
    beat(rep(8'h11));
    err_clr_i = 1'b1;
    beat(rep(8'h22));
    err_clr_i = 1'b0;
    check("wrap_addr", err_addr_o, 0);
    check("wrap_set_wins", err_flag_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    // Overrun while armed leaves the descriptor intact.
    desc(32'd400, 4'd0, 4'd15, 10'd1, 1'b0, 8'h77);
    desc(32'd500, 4'd0, 4'd15, 10'd0, 1'b0, 8'h88);
    check("t5_ovr", ovr_flag_o, 1);
    check("t5_busy", cmp_busy_o, 1);
    beat(rep(8'h77));
    check("t5_not_done_early", cmp_done_o, 0);
    beat(rep(8'h77));
    check("t5_done", cmp_done_o, 1);
    check("t5_pass", pass_cnt_o, 6);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t5_ovr_clr", ovr_flag_o, 0);
    beat(rep(8'h77));
    tick();
    check("idle_beat_busy", cmp_busy_o, 0);
    check("idle_beat_pulses", {cmp_done_o, cmp_error_o}, 0);
    check("idle_beat_pass", pass_cnt_o, 6);
    // Async reset mid-check.
    desc(32'd600, 4'd0, 4'd15, 10'd3, 1'b0, 8'h99);
    beat(rep(8'h99));
    beat(rep(8'h99));
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", cmp_busy_o, 0);
    check("arst_pass", pass_cnt_o, 0);
    check("arst_pulses", {cmp_done_o, cmp_error_o}, 0);
    check("arst_addr", err_addr_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("arst_no_pulse", {cmp_done_o, cmp_error_o, cmp_busy_o}, 0);
    for (int k = 0; k < 3; k++) begin
      desc(32'd700, 4'd0, 4'd15, 10'd0, 1'b0, 8'h01);
      beat(rep(8'h02));
      check("cnt_error", cmp_error_o, 1);
    end
    tick();
`ifdef CMP_ERR_CNT_EN
    check("err_cnt", err_cnt_o, 3);
`else
    check("err_cnt", err_cnt_o, 0);
`endif
    check("final_pass", pass_cnt_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
